// File: rtl/acc_dump_tx.sv
// Accumulator dump transmitter: captures i_ACC on a start request and sends it LSB byte first as UART frames.
// Optional even-parity bit per frame when ACC_DUMP_PARITY_EN is defined (8E1 instead of 8N1).
module acc_dump_tx #(
    parameter int NBITS_D     = 16,
    parameter int CLK_PER_BIT = 868
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NBITS_D-1:0] i_ACC,
    input  logic               i_start,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam int N_BYTES  = (NBITS_D + 7) / 8;
    localparam int SHADOW_W = N_BYTES * 8;
    localparam int BAUD_W   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int BYTE_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef ACC_DUMP_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]     byte_idx_q, byte_idx_d;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d;
    logic                  done_q, done_d;

    logic                  bit_end;
    logic                  last_byte;
    logic [7:0]            cur_byte;

    assign bit_end   = (baud_cnt_q == BAUD_LAST);
    assign last_byte = (byte_idx_q == BYTE_LAST);
    // The shadow register shifts down one byte per frame, so the active byte is always the low one.
    assign cur_byte  = shadow_q[7:0];

    // State register plus the datapath flops that move with it.
    always_ff @(posedge i_clock) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
        if (i_reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shadow_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shadow_q   <= shadow_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx_q == 3'd7)) begin
`ifdef ACC_DUMP_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef ACC_DUMP_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = last_byte ? S_IDLE : S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, shadow register and the registered done pulse.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shadow_d   = shadow_q;
        done_d     = 1'b0;

        // Every state change happens on a bit boundary, so wrapping here also restarts on entry.
        if (state_q == S_IDLE || bit_end) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    shadow_d   = SHADOW_W'(i_ACC);
                    byte_idx_d = '0;
                end
            end
            S_START: begin
                bit_idx_d = '0;
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (last_byte) begin
                        byte_idx_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                        shadow_d   = shadow_q >> 8;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output logic, decoded from registered state only.
    always_comb begin
        o_tx   = 1'b1;
        o_busy = 1'b1;
        o_done = done_q;
        case (state_q)
            S_IDLE:   o_busy = 1'b0;
            S_START:  o_tx   = 1'b0;
            S_DATA:   o_tx   = cur_byte[bit_idx_q];
`ifdef ACC_DUMP_PARITY_EN
            S_PARITY: o_tx   = ^cur_byte;
`endif
            S_STOP:   o_tx   = 1'b1;
            default:  o_busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_acc_dump_tx.sv
// Self-checking bench for acc_dump_tx (CLK_PER_BIT=4, NBITS_D=16); honours ACC_DUMP_PARITY_EN.
module tb_acc_dump_tx;

    localparam int NBITS_D = 16;
    localparam int CPB     = 4;
    localparam int N_BYTES = 2;
`ifdef ACC_DUMP_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int EXP_BUSY   = 88;
`else
    localparam int FRAME_BITS = 10;
    localparam int EXP_BUSY   = 80;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [NBITS_D-1:0] acc;
    logic               tx;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Model: a queue holding the expected line level for every remaining busy cycle.
    bit   exp_q[$];
    logic exp_done = 1'b0;

    acc_dump_tx #(
        .NBITS_D    (NBITS_D),
        .CLK_PER_BIT(CPB)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_ACC  (acc),
        .i_start(start),
        .o_tx   (tx),
        .o_busy (busy),
        .o_done (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_frames(input logic [NBITS_D-1:0] v);
        logic [7:0] byt;
        for (int b = 0; b < N_BYTES; b++) begin
            byt = v[8*b +: 8];
            repeat (CPB) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) exp_q.push_back(byt[i]);
            end
`ifdef ACC_DUMP_PARITY_EN
            repeat (CPB) exp_q.push_back(^byt);
`endif
            repeat (CPB) exp_q.push_back(1'b1);
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done <= 1'b0;
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            exp_done <= (exp_q.size() == 0);
        end else begin
            exp_done <= 1'b0;
            if (start) begin
                push_frames(acc);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_tx", tx, (exp_q.size() > 0) ? exp_q[0] : 1'b1);
            check("model_busy", busy, exp_q.size() > 0);
            check("model_done", done, exp_done);
        end
    end

    // One transfer with hand-computed byte values, decoded from the line by mid-bit sampling.
    task automatic do_transfer(input logic [15:0] v, input logic [7:0] b0, input logic [7:0] b1,
                               input bit p0, input bit p1, input bit disturb, input string tag);
        logic       samp [0:511];
        logic [7:0] byt;
        int         cyc;
        int         base;
        acc   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 400) begin
            samp[cyc] = tx;
            cyc++;
            if (disturb && cyc == 20) begin
                start = 1'b1;
                acc   = 16'hFFFF;
            end
            if (disturb && cyc == 22) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_busy_len"}, cyc, EXP_BUSY);
        check({tag, "_done_pulse"}, done, 1'b1);
        for (int b = 0; b < N_BYTES; b++) begin
            base = b * FRAME_BITS * CPB;
            check({tag, "_start_bit"}, samp[base + CPB/2], 1'b0);
            for (int i = 0; i < 8; i++) begin
                byt[i] = samp[base + (1 + i) * CPB + CPB/2];
            end
            check({tag, "_byte"}, byt, (b == 0) ? b0 : b1);
`ifdef ACC_DUMP_PARITY_EN
            check({tag, "_parity"}, samp[base + 9 * CPB + CPB/2], (b == 0) ? p0 : p1);
`else
            if (p0 != p1) begin
                check({tag, "_parity_args"}, p0, p1);
            end
`endif
            check({tag, "_stop_bit"}, samp[base + (FRAME_BITS - 1) * CPB + CPB/2], 1'b1);
        end
        @(negedge clk);
        check({tag, "_done_single"}, done, 1'b0);
    endtask

    initial begin
        int busy_len;
        int idle_len;
        int n_done;

        rst   = 1'b1;
        start = 1'b0;
        acc   = '0;
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0;

        repeat (50) begin
            @(negedge clk);
            check("idle_tx", tx, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
        end

        do_transfer(16'hA53C, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, "xfer");
        do_transfer(16'hA53C, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b1, "disturb");
        do_transfer(16'h0107, 8'h07, 8'h01, 1'b1, 1'b1, 1'b0, "p0107");

        // Reset in the 30th busy cycle of a transfer.
        acc   = 16'hA53C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("mid_rst_no_done", done, 1'b0);
        end

        // Start and reset together: reset wins.
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        check("rst_start_busy", busy, 1'b0);
        check("rst_start_tx", tx, 1'b1);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_after", busy, 1'b0);

        // Start held high: back-to-back transfers with a single idle cycle between them.
        acc      = 16'hA53C;
        start    = 1'b1;
        busy_len = 0;
        idle_len = 0;
        n_done   = 0;
        for (int c = 0; c < 1000 && n_done < 3; c++) begin
            @(negedge clk);
            if (busy) begin
                if (idle_len > 0) begin
                    check("held_gap", idle_len, 1);
                    idle_len = 0;
                end
                busy_len++;
            end else begin
                if (busy_len > 0) begin
                    check("held_len", busy_len, EXP_BUSY);
                    check("held_done", done, 1'b1);
                    n_done++;
                    busy_len = 0;
                end else begin
                    check("held_idle_no_done", done, 1'b0);
                end
                idle_len++;
            end
        end
        check("held_done_count", n_done, 3);
        start = 1'b0;
        for (int c = 0; c < 200 && busy; c++) begin
            @(negedge clk);
        end
        check("held_drain", busy, 1'b0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
